sda_serial_io: RTL and testbench
================================

Name: sda_serial_io

Overview:
- Parametrised serial-data I/O engine. Successor to the single-bit tristate SDA driver.
- Shifts one DATA_W-bit word out of, or into, a tristate sda pin, followed by one acknowledge bit.
- Generates its own scl from m_clk via a divider.
- Sits between the protocol controller (start/mode/data handshake) and the bidirectional pad.

Parameters:
- DATA_W, 8: bits per transfer (>=1).
- CLK_DIV, 4: m_clk cycles per scl half-period (>=1).
- MSB_FIRST, 1: 1 = shift MSB first; 0 = shift LSB first.

Ports:
- m_clk  input  1  system clock, rising-edge.
- m_rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a transfer; sampled only in IDLE.
- mode  input  1  0 = transmit, 1 = receive; latched with start.
- tx_data  input  DATA_W  word to send; latched with start.
- rx_ack  input  1  receive mode: 1 = drive ACK (0) in ack slot, 0 = release (NACK); latched with start.
- busy  output  1  high from the cycle after start is accepted until return to IDLE.
- done  output  1  one-cycle pulse at end of transfer.
- rx_data  output  DATA_W  last received word; holds until the next receive completes.
- ack_bit  output  1  ack level sampled in the last transmit; holds until the next transmit completes.
- scl  output  1  serial clock.
- sda_oe  output  1  pad output enable (observability).
- sda  inout  1  serial data; driven by sda_buf when sda_oe=1, else high-Z.

Behaviour:
- Reset (async, immediate):
  - State IDLE, scl=1, sda_oe=0 (sda released), sda_buf=0.
  - busy=0, done=0, rx_data=0, ack_bit=1.
  - Divider and bit counters 0.
  - A reset mid-transfer aborts with no done pulse.
- State machine: IDLE, LOW, HIGH, ACK_LOW, ACK_HIGH, DONE.
- Divider cnt counts 0..CLK_DIV-1 in every non-IDLE/non-DONE state; it clears on every state change.
- IDLE:
  - scl=1, sda_oe=0.
  - On a clock edge with start=1: latch mode, tx_data into the shift register, and rx_ack; bit_idx=0; go to LOW.
- LOW (scl=0):
  - On entry, transmit mode sets sda_oe=1 and sda_buf to the current bit (MSB or LSB per MSB_FIRST).
  - Receive mode sets sda_oe=0.
  - At cnt==CLK_DIV-1, go to HIGH.
- HIGH (scl=1):
  - At cnt==CLK_DIV-1, receive mode shifts the sampled sda into the shift register and bit_idx increments.
  - If bit_idx was DATA_W-1, go to ACK_LOW; otherwise go to LOW.
- ACK_LOW (scl=0):
  - Transmit mode: sda_oe=0.
  - Receive mode: sda_oe=rx_ack, sda_buf=0.
  - After CLK_DIV cycles, go to ACK_HIGH.
- ACK_HIGH (scl=1):
  - Same sda drive as ACK_LOW.
  - At cnt==CLK_DIV-1: transmit mode latches sda into ack_bit; receive mode copies the shift register to rx_data. Go to DONE.
- DONE: scl=1, sda_oe=0, done=1 for exactly one cycle, then IDLE.
- Latency: start accepted at edge E0. DONE is entered at edge E0 + 2*CLK_DIV*(DATA_W+1); done is high for the cycle after that edge. busy=0 one cycle later.
- start while busy, or during DONE: ignored; latched values are unaffected.
- start held high continuously: a new transfer begins on the first IDLE cycle, so back-to-back transfers are separated by one IDLE cycle.
- X/Z on sda when sampled: captured as-is; the bench must always provide a pull-up.

Test Plan:
- Default parameters, CLK_DIV=2:
  - Stimulus: transmit tx_data=0xA5; bench drives sda=0 during ACK_HIGH.
  - Required: sda on successive scl rises is 1,0,1,0,0,1,0,1; ack_bit=0; done high exactly one cycle, 36 edges after acceptance; busy low the next cycle.
- Receive with rx_ack=1:
  - Stimulus: bench drives 0x3C MSB-first, changing only while scl=0.
  - Required: rx_data=0x3C after done; sda_oe=1 and sda=0 through ACK_LOW/ACK_HIGH; sda_oe=0 during data bits.
- Transmit 0xFF with the bench releasing sda (pull-up) in the ack slot:
  - Required: ack_bit=1; sda_oe=0 during both ack states.
- MSB_FIRST=0, transmit 0x01:
  - Required: first bit 1 followed by seven 0s; scl high time = low time = CLK_DIV cycles.
- Reset after the third scl rise of a transmit:
  - Required: the same cycle shows sda_oe=0, scl=1, busy=0, and no done pulse.
  - Then transmit 0x5A: completes normally with correct bits.
- Start re-asserted with tx_data=0x00 mid-transfer of 0xC3:
  - Required: 0xC3 is sent unchanged; a single done pulse; the second start is honoured only once back in IDLE.

Source files
------------

// File: rtl/sda_serial_io.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : sda_serial_io
// Shifts one DATA_W-bit word over a tristate sda pin plus an acknowledge bit,
// generating scl from m_clk with a CLK_DIV divider.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module sda_serial_io #(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic              m_clk,
  input  logic              m_rst,
  input  logic              start,
  input  logic              mode,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              ack_bit,
  output logic              scl,
  output logic              sda_oe,
  inout  wire               sda
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOW      = 3'd1,
    HIGH     = 3'd2,
    ACK_LOW  = 3'd3,
    ACK_HIGH = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic [DATA_W-1:0]   sh_next;
  logic [DATA_W:0]     sh_cat;
  logic                mode_q, mode_d;
  logic                rx_ack_q, rx_ack_d;
  logic                scl_q, scl_d;
  logic                sda_oe_q, sda_oe_d;
  logic                sda_buf_q, sda_buf_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic                ack_bit_q, ack_bit_d;
  logic                cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // One shift serves both directions: transmit drives the outgoing end,
  // receive fills from the sampled pin on the opposite end.
  always_comb begin
    if (MSB_FIRST) begin
      sh_cat  = {sh_q, sda};
      sh_next = sh_cat[DATA_W-1:0];
    end else begin
      sh_cat  = {sda, sh_q};
      sh_next = sh_cat[DATA_W:1];
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    sh_d      = sh_q;
    mode_d    = mode_q;
    rx_ack_d  = rx_ack_q;
    rx_data_d = rx_data_q;
    ack_bit_d = ack_bit_q;
    sda_buf_d = sda_buf_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = LOW;
          mode_d   = mode;
          rx_ack_d = rx_ack;
          sh_d     = tx_data;
          idx_d    = '0;
        end
      end
      LOW: begin
        if (cnt_last) state_d = HIGH;
      end
      HIGH: begin
        if (cnt_last) begin
          sh_d    = sh_next;
          idx_d   = idx_q + 1'b1;
          state_d = (idx_q == IDX_LAST) ? ACK_LOW : LOW;
        end
      end
      ACK_LOW: begin
        if (cnt_last) state_d = ACK_HIGH;
      end
      ACK_HIGH: begin
        if (cnt_last) begin
          if (mode_q) rx_data_d = sh_q;
          else        ack_bit_d = sda;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d != state_q || state_q == IDLE || state_q == DONE) cnt_d = '0;
    else                                                          cnt_d = cnt_q + 1'b1;

    // Outputs are decoded from the next state so they line up with it.
    scl_d  = !(state_d == LOW || state_d == ACK_LOW);
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);

    case (state_d)
      LOW, HIGH:         sda_oe_d = !mode_d;
      ACK_LOW, ACK_HIGH: sda_oe_d = mode_d & rx_ack_d;
      default:           sda_oe_d = 1'b0;
    endcase

    if (state_d == LOW && state_q != LOW)
      sda_buf_d = MSB_FIRST ? sh_d[DATA_W-1] : sh_d[0];
    else if (state_d == ACK_LOW && state_q != ACK_LOW)
      sda_buf_d = 1'b0;
  end

  always_ff @(posedge m_clk or posedge m_rst) begin
    if (m_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      sh_q      <= '0;
      mode_q    <= 1'b0;
      rx_ack_q  <= 1'b0;
      scl_q     <= 1'b1;
      sda_oe_q  <= 1'b0;
      sda_buf_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rx_data_q <= '0;
      ack_bit_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      sh_q      <= sh_d;
      mode_q    <= mode_d;
      rx_ack_q  <= rx_ack_d;
      scl_q     <= scl_d;
      sda_oe_q  <= sda_oe_d;
      sda_buf_q <= sda_buf_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rx_data_q <= rx_data_d;
      ack_bit_q <= ack_bit_d;
    end
  end

  assign sda     = sda_oe_q ? sda_buf_q : 1'bz;
  assign scl     = scl_q;
  assign sda_oe  = sda_oe_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign ack_bit = ack_bit_q;

endmodule

`default_nettype wire

// File: tb/tb_sda_serial_io.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_sda_serial_io
// Directed and randomized transfers on two sda_serial_io instances.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_sda_serial_io;

  localparam int DW   = 8;
  localparam int DIV  = 2;
  localparam int LDIV = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   checks = 0;
  int   errors = 0;

  // MSB-first instance, CLK_DIV=2, with a bench driver on sda
  logic          start, mode, rx_ack;
  logic [DW-1:0] tx_data;
  wire           busy, done, ack_bit, scl, sda_oe;
  wire  [DW-1:0] rx_data;
  wire           sda;
  logic          tb_oe, tb_bit;
  assign sda = tb_oe ? tb_bit : 1'bz;
  pullup pu_a (sda);

  sda_serial_io #(.DATA_W(DW), .CLK_DIV(DIV), .MSB_FIRST(1'b1)) u_dut (
    .m_clk(clk), .m_rst(rst), .start(start), .mode(mode), .tx_data(tx_data),
    .rx_ack(rx_ack), .busy(busy), .done(done), .rx_data(rx_data),
    .ack_bit(ack_bit), .scl(scl), .sda_oe(sda_oe), .sda(sda)
  );

  // LSB-first instance, CLK_DIV=3, transmit only, pull-up alone on sda
  logic          l_start;
  logic          l_mode = 1'b0;
  logic          l_rx_ack = 1'b0;
  logic [DW-1:0] l_tx;
  wire           l_busy, l_done, l_ack, l_scl, l_oe;
  wire  [DW-1:0] l_rx_data;
  wire           l_sda;
  pullup pu_b (l_sda);

  sda_serial_io #(.DATA_W(DW), .CLK_DIV(LDIV), .MSB_FIRST(1'b0)) u_lsb (
    .m_clk(clk), .m_rst(rst), .start(l_start), .mode(l_mode), .tx_data(l_tx),
    .rx_ack(l_rx_ack), .busy(l_busy), .done(l_done), .rx_data(l_rx_data),
    .ack_bit(l_ack), .scl(l_scl), .sda_oe(l_oe), .sda(l_sda)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transmit one word from u_dut; the model is the bit order of the word,
  // the fixed transfer length and the bench's own ack choice.
  task automatic do_tx(input logic [DW-1:0] word, input bit ack_low,
                       input int restart_at, input string tag);
    int n, rises, done_n;
    bit prev_scl;
    mode = 1'b0; rx_ack = 1'b0; tx_data = word; start = 1'b1;
    tick();
    start = 1'b0;
    tx_data = ~word;
    chk({tag, "_busy"}, busy, 1);
    n = 0; rises = 0; done_n = 0; prev_scl = scl;
    while (done_n == 0 && n < 200) begin
      if (n == restart_at) begin start = 1'b1; tx_data = '0; end
      tick();
      n++;
      if (scl && !prev_scl) begin
        if (rises < DW) begin
          chk({tag, "_bit"}, sda, (word >> (DW - 1 - rises)) & 1);
          chk({tag, "_oe_data"}, sda_oe, 1);
        end
        rises++;
      end
      prev_scl = scl;
      if (rises == DW && !scl) begin
        tb_oe = ack_low; tb_bit = 1'b0;
        chk({tag, "_oe_acklow"}, sda_oe, 0);
      end
      if (rises == DW + 1 && !done) chk({tag, "_oe_ackhigh"}, sda_oe, 0);
      if (done) done_n = n;
    end
    tb_oe = 1'b0;
    chk({tag, "_done_at"}, done_n, 2 * DIV * (DW + 1));
    chk({tag, "_ack_bit"}, ack_bit, !ack_low);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  // Receive one word into u_dut; the bench plays the remote transmitter,
  // changing sda only while scl is low.
  task automatic do_rx(input logic [DW-1:0] word, input bit ack, input string tag);
    int n, rises, done_n;
    bit prev_scl;
    mode = 1'b1; rx_ack = ack; tx_data = DW'($urandom); start = 1'b1;
    tick();
    start = 1'b0; mode = 1'b0; rx_ack = !ack;
    n = 0; rises = 0; done_n = 0; prev_scl = scl;
    tb_oe = 1'b1; tb_bit = word[DW-1];
    while (done_n == 0 && n < 200) begin
      tick();
      n++;
      if (scl && !prev_scl) rises++;
      prev_scl = scl;
      if (!scl && rises < DW) begin tb_oe = 1'b1; tb_bit = (word >> (DW - 1 - rises)) & 1; end
      if (!scl && rises == DW) tb_oe = 1'b0;
      if (rises < DW) chk({tag, "_oe_data"}, sda_oe, 0);
      if (!done && ((rises == DW && !scl) || rises == DW + 1))
        chk({tag, "_oe_ack"}, sda_oe, ack);
      if (!done && rises == DW + 1) chk({tag, "_sda_ack"}, sda, !ack);
      if (done) done_n = n;
    end
    tb_oe = 1'b0;
    chk({tag, "_done_at"}, done_n, 2 * DIV * (DW + 1));
    chk({tag, "_rx_data"}, rx_data, word);
    tick();
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_end"}, busy, 0);
  endtask

  // LSB-first transmit on u_lsb, also measuring scl half-period lengths.
  task automatic do_lsb(input logic [DW-1:0] word, input string tag);
    int n, rises, done_n, run;
    bit prev_scl;
    l_tx = word; l_start = 1'b1;
    tick();
    l_start = 1'b0;
    n = 0; rises = 0; done_n = 0; prev_scl = l_scl; run = 1;
    while (done_n == 0 && n < 300) begin
      tick();
      n++;
      if (l_scl != prev_scl) begin
        chk({tag, "_half_period"}, run, LDIV);
        run = 1;
      end else begin
        run++;
      end
      if (l_scl && !prev_scl) begin
        if (rises < DW) chk({tag, "_bit"}, l_sda, (word >> rises) & 1);
        rises++;
      end
      prev_scl = l_scl;
      if (l_done) done_n = n;
    end
    chk({tag, "_done_at"}, done_n, 2 * LDIV * (DW + 1));
    chk({tag, "_ack_bit"}, l_ack, 1);
    tick();
    chk({tag, "_busy_end"}, l_busy, 0);
  endtask

  initial begin
    int n, rises;
    bit prev_scl;
    logic [DW-1:0] w;
    logic [DW-1:0] held_rx;
    bit a;

    rst = 1'b1; start = 1'b0; mode = 1'b0; rx_ack = 1'b0; tx_data = '0;
    tb_oe = 1'b0; tb_bit = 1'b0; l_start = 1'b0; l_tx = '0;
    tick(); tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_scl", scl, 1);
    chk("rst_oe", sda_oe, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ack_bit", ack_bit, 1);
    chk("rst_sda_released", sda, 1);
    chk("rst_lsb_scl", l_scl, 1);
    rst = 1'b0;
    tick();

    do_tx(8'hA5, 1'b1, -1, "tx_a5");
    do_rx(8'h3C, 1'b1, "rx_3c");
    held_rx = rx_data;
    do_tx(8'hFF, 1'b0, -1, "tx_ff_nack");
    chk("rx_data_held", rx_data, held_rx);

    do_lsb(8'h01, "lsb_01");
    do_lsb(DW'($urandom), "lsb_rand");

    // reset after the third scl rise of a transmit
    mode = 1'b0; tx_data = 8'h96; start = 1'b1;
    tick();
    start = 1'b0;
    n = 0; rises = 0; prev_scl = scl;
    while (rises < 3 && n < 100) begin
      tick();
      n++;
      if (scl && !prev_scl) rises++;
      prev_scl = scl;
    end
    chk("abort_reached_rise3", rises, 3);
    #2 rst = 1'b1;
    #1;
    chk("abort_oe", sda_oe, 0);
    chk("abort_scl", scl, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("abort_no_done", done, 0);
    end
    rst = 1'b0;
    tick();
    do_tx(8'h5A, 1'b1, -1, "tx_5a_after_rst");

    // start re-asserted mid-transfer is ignored until back in IDLE
    do_tx(8'hC3, 1'b1, 10, "tx_c3_restart");
    chk("restart_start_held", start, 1);
    do_tx(8'h00, 1'b0, -1, "tx_00_second");

    for (int i = 0; i < 4; i++) begin
      w = DW'($urandom);
      a = 1'($urandom);
      do_tx(w, a, -1, "tx_rand");
      w = DW'($urandom);
      a = 1'($urandom);
      do_rx(w, a, "rx_rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
